// File: rtl/instruction_prefetch_buffer_pkg.sv
// Shared pipeline-register types for the fetch/decode boundary and the redirect path.
// Used by instruction_prefetch_buffer and its FIFO.
package instruction_prefetch_buffer_pkg;

    localparam int INSTR_BYTES = 4;

    typedef logic [31:0] UWord;
    typedef logic [31:0] RomAddress;

    typedef struct packed {
        UWord      instr;
        RomAddress pc;
        RomAddress next_pc;
    } IfIdReg;

    typedef struct packed {
        logic      should_branch;
        RomAddress branch_target;
    } MemIfReg;

    function automatic RomAddress align_word(input RomAddress a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_prefetch_buffer_fifo.sv
// prefetch_fifo: generic synchronous FIFO with flush; the head is held in its own register
// so it stays stable (last contents) when the FIFO drains.
module prefetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  T                       i_din,
    output T                       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    T                r_head;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW:0]     r_count;

    logic            w_do_pop;
    logic            w_do_push;
    logic [PW-1:0]   w_rd_next;

    assign w_do_pop  = i_pop & (r_count != '0) & ~i_flush;
    assign w_do_push = i_push & ((r_count < (PW+1)'(DEPTH)) | w_do_pop) & ~i_flush;
    assign w_rd_next = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= w_rd_next;
            r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
            // Next head is either the entry behind the current one, or the incoming word when it lands in an empty slot.
            if (w_do_pop && r_count > (PW+1)'(1))
                r_head <= r_mem[w_rd_next];
            else if (w_do_push && (r_count == '0 || (w_do_pop && r_count == (PW+1)'(1))))
                r_head <= i_din;
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Decoupled instruction prefetcher: sequential ROM fetch into a FIFO, valid/ready to decode, flush on redirect.
// Optional PREFETCH_PERF_EN adds flush_count / stall_count counters.
module instruction_prefetch_buffer
    import instruction_prefetch_buffer_pkg::*;
#(
    parameter int        DEPTH    = 4,
    parameter RomAddress RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  MemIfReg                redirect,
    input  UWord                   rom_data,
    output RomAddress              rom_address,
    output IfIdReg                 out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   misaligned
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0]            flush_count,
    output logic [31:0]            stall_count
`endif
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    RomAddress r_fetch_pc;
    logic      r_misaligned;
    logic      w_branch;
    logic      w_pop;
    logic      w_push;
    RomAddress w_pc_next;
    IfIdReg    w_entry;

    assign w_branch  = redirect.should_branch;
    assign out_valid = (occupancy != '0);
    // A redirect kills both sides of the handshake for this cycle.
    assign w_pop     = out_valid & out_ready & ~w_branch;
    assign w_push    = ~w_branch & ((occupancy < OCC_W'(DEPTH)) | w_pop);
    assign w_pc_next = r_fetch_pc + RomAddress'(INSTR_BYTES);
    assign w_entry   = '{instr: rom_data, pc: r_fetch_pc, next_pc: w_pc_next};

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .T     (IfIdReg)
    ) u_fifo (
        .clk     (clk),
        .i_reset (reset),
        .i_flush (w_branch),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_entry),
        .o_head  (out),
        .o_count (occupancy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc   <= RESET_PC;
            r_misaligned <= 1'b0;
        end else if (w_branch) begin
            r_fetch_pc <= align_word(redirect.branch_target);
            if (redirect.branch_target[1:0] != 2'b00)
                r_misaligned <= 1'b1;
        end else if (w_push) begin
            r_fetch_pc <= w_pc_next;
        end
    end

    assign rom_address = r_fetch_pc;
    assign misaligned  = r_misaligned;

`ifdef PREFETCH_PERF_EN
    logic [31:0] r_flush_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_branch)
                r_flush_count <= r_flush_count + 32'(occupancy);
            if (out_valid && !out_ready)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign flush_count = r_flush_count;
    assign stall_count = r_stall_count;
`endif

endmodule
